// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the KEY/SW input conditioning path: debounce FSM states
// and the default sample counts used by the board-level instances.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LO    = 2'd0,
    S_LO2HI = 2'd1,
    S_HI    = 2'd2,
    S_HI2LO = 2'd3
  } debounce_state_t;

  // Sample counts at the 1 kHz strobe: 20 ms for push buttons, 10 ms for slide switches.
  localparam int DEBOUNCE_KEY_DEFAULT = 20;
  localparam int DEBOUNCE_SW_DEFAULT  = 10;

endpackage

// File: rtl/input_debouncer_channel.sv
// One input channel: 2-flop synchronizer followed by a debounce FSM that accepts a new
// level after DEBOUNCE_CNT consecutive strobe-qualified samples, with registered edge pulses.
module input_debouncer_channel
  import input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_KEY_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic level,
  output logic pressed_pulse,
  output logic released_pulse
);

  localparam int              CW   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CNT - 1);

  debounce_state_t state;
  logic            sync1;
  logic            sync2;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      state          <= S_LO;
      cnt            <= '0;
      level          <= 1'b0;
      pressed_pulse  <= 1'b0;
      released_pulse <= 1'b0;
    end else begin
      sync1          <= din;
      sync2          <= sync1;
      pressed_pulse  <= 1'b0;
      released_pulse <= 1'b0;
      unique case (state)
        // The edge that first sees the new value counts as a sample when en is high.
        S_LO: begin
          if (sync2) begin
            if (en && (LAST == '0)) begin
              state         <= S_HI;
              level         <= 1'b1;
              pressed_pulse <= 1'b1;
              cnt           <= '0;
            end else begin
              state <= S_LO2HI;
              cnt   <= en ? CW'(1) : '0;
            end
          end
        end
        S_LO2HI: begin
          if (!sync2) begin
            state <= S_LO;
            cnt   <= '0;
          end else if (en) begin
            if (cnt == LAST) begin
              state         <= S_HI;
              level         <= 1'b1;
              pressed_pulse <= 1'b1;
              cnt           <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_HI: begin
          if (!sync2) begin
            if (en && (LAST == '0)) begin
              state          <= S_LO;
              level          <= 1'b0;
              released_pulse <= 1'b1;
              cnt            <= '0;
            end else begin
              state <= S_HI2LO;
              cnt   <= en ? CW'(1) : '0;
            end
          end
        end
        S_HI2LO: begin
          if (sync2) begin
            state <= S_HI;
            cnt   <= '0;
          end else if (en) begin
            if (cnt == LAST) begin
              state          <= S_LO;
              level          <= 1'b0;
              released_pulse <= 1'b1;
              cnt            <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= S_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Conditions raw DE1-SoC KEY/SW pins: polarity normalization then N independent
// synchronize-and-debounce channels producing a clean level and press/release pulses.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int N            = 4,
  parameter int DEBOUNCE_CNT = DEBOUNCE_KEY_DEFAULT,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level,
  output logic [N-1:0] pressed_pulse,
  output logic [N-1:0] released_pulse
);

  // After this XOR, 1 always means "asserted" regardless of pin polarity.
  logic [N-1:0] norm;
  assign norm = raw_in ^ {N{ACTIVE_LOW}};

  for (genvar i = 0; i < N; i++) begin : g_ch
    input_debouncer_channel #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .din           (norm[i]),
      .level         (level[i]),
      .pressed_pulse (pressed_pulse[i]),
      .released_pulse(released_pulse[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (N=4, DEBOUNCE_CNT=4, active-low KEYs): directed vector table,
// hand-built corner sequences and randomized bouncing inputs against a run-length model.
module tb_input_debouncer;

  localparam int N   = 4;
  localparam int CNT = 4;
  localparam bit AL  = 1'b1;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [N-1:0] raw_in;
  logic [N-1:0] level;
  logic [N-1:0] pressed_pulse;
  logic [N-1:0] released_pulse;

  always #5 clk = ~clk;

  input_debouncer #(
    .N(N),
    .DEBOUNCE_CNT(CNT),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .raw_in        (raw_in),
    .level         (level),
    .pressed_pulse (pressed_pulse),
    .released_pulse(released_pulse)
  );

  int checks = 0;
  int passes = 0;

  // Model: a value two clocks old is "seen"; a level flips once CNT strobed samples have
  // seen the opposite value with no clock in between where it matched the level again.
  logic [N-1:0] m_hist1, m_hist2, m_level, m_press, m_rel;
  int           m_run[N];

  task automatic model_edge();
    logic [N-1:0] norm;
    norm = raw_in ^ {N{AL}};
    if (reset) begin
      m_hist1 = '0; m_hist2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N; i++) begin
        if (m_hist2[i] == m_level[i]) m_run[i] = 0;
        else if (en) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == CNT) begin
            m_level[i] = ~m_level[i];
            if (m_level[i]) m_press[i] = 1'b1;
            else            m_rel[i]   = 1'b1;
            m_run[i] = 0;
          end
        end
      end
      m_hist2 = m_hist1;
      m_hist1 = norm;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic e, input logic [N-1:0] raw);
    @(negedge clk);
    reset  = r;
    en     = e;
    raw_in = raw;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic r, input logic e, input logic [N-1:0] raw);
    drive(r, e, raw);
    check("model", {20'd0, level, pressed_pulse, released_pulse}, {20'd0, m_level, m_press, m_rel});
  endtask

  typedef struct {
    logic         rst;
    logic         en;
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } vec_t;

  vec_t tq[$];

  task automatic add(input int rep, input logic r, input logic [N-1:0] raw,
                     input logic [N-1:0] lvl, input logic [N-1:0] prs, input logic [N-1:0] rls);
    vec_t v;
    v.rst = r; v.en = 1'b1; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rls = rls;
    for (int k = 0; k < rep; k++) tq.push_back(v);
  endtask

  initial begin
    logic [N-1:0] seen_pulse;
    logic [N-1:0] rel_val;
    int           rise_k;
    int           rel_k;
    logic [N-1:0] r;

    reset  = 1'b1;
    en     = 1'b1;
    raw_in = '0;

    // Reset with all keys pressed, then accept, then release/press channel 0.
    add(3, 1'b1, 4'b0000, 4'h0, 4'h0, 4'h0);
    add(5, 1'b0, 4'b0000, 4'h0, 4'h0, 4'h0);
    add(1, 1'b0, 4'b0000, 4'hF, 4'hF, 4'h0);
    add(1, 1'b0, 4'b0000, 4'hF, 4'h0, 4'h0);
    add(5, 1'b0, 4'b0001, 4'hF, 4'h0, 4'h0);
    add(1, 1'b0, 4'b0001, 4'hE, 4'h0, 4'h1);
    add(2, 1'b0, 4'b0001, 4'hE, 4'h0, 4'h0);
    add(5, 1'b0, 4'b0000, 4'hE, 4'h0, 4'h0);
    add(1, 1'b0, 4'b0000, 4'hF, 4'h1, 4'h0);
    add(1, 1'b0, 4'b0000, 4'hF, 4'h0, 4'h0);
    foreach (tq[i]) begin
      drive(tq[i].rst, tq[i].en, tq[i].raw);
      check($sformatf("vec%0d", i), {20'd0, level, pressed_pulse, released_pulse},
            {20'd0, tq[i].lvl, tq[i].prs, tq[i].rls});
    end

    // Short press on channel 1 (3 clk) must be rejected.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 4'b0010);
    seen_pulse = '0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 4'b0000);
      seen_pulse |= pressed_pulse | released_pulse;
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 4'b0010);
      seen_pulse |= pressed_pulse | released_pulse;
    end
    check("bounce_level", {28'd0, level}, 32'h0000_000D);
    check("bounce_pulse", {28'd0, seen_pulse}, 32'd0);

    // Channel 2 pressed with a 1-in-10 strobe; acceptance on the 4th strobe after sync.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 4'b0110);
    check("ch2_released", {28'd0, level}, 32'h0000_0009);
    rise_k = 0;
    for (int k = 1; k <= 60; k++) begin
      step(1'b0, (k % 10) == 0, 4'b0010);
      if (level[2] && rise_k == 0) rise_k = k;
    end
    check("strobe_rise", rise_k, 40);

    // Release channel 3, reset while it is mid-debounce: no release pulse, level cleared.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'b1010);
    step(1'b1, 1'b1, 4'b1010);
    check("reset_mid", {20'd0, level, pressed_pulse, released_pulse}, 32'd0);
    seen_pulse = '0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 4'b1010);
      seen_pulse |= released_pulse;
    end
    check("after_reset_level", {28'd0, level}, 32'h0000_0005);
    check("after_reset_norel", {28'd0, seen_pulse}, 32'd0);

    // Simultaneous release of channels 0 and 3.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 4'b0010);
    check("held_level", {28'd0, level}, 32'h0000_000D);
    rel_val = '0;
    rel_k   = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 4'b1011);
      if (released_pulse != '0 && rel_k == 0) begin
        rel_k   = k;
        rel_val = released_pulse;
      end
    end
    check("dual_release_val", {28'd0, rel_val}, 32'h0000_0009);
    check("dual_release_clk", rel_k, 6);
    check("dual_release_lvl", {28'd0, level}, 32'h0000_0004);

    // Randomized bouncing inputs, irregular strobe, occasional reset.
    r = raw_in;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
      step($urandom_range(0, 499) == 0,
           (k >= 1500) ? 1'b1 : ($urandom_range(0, 2) != 0), r);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
